// File: rtl/wb_stage_if.sv
// Bus bundle for the writeback stage: execute handshake, load port and register-file write port.
// The stage itself uses the slave view; the execute/memory environment uses the master view.
interface wb_stage_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_alu;
    logic [15:0] in_pc;
    logic [15:0] in_imm;
    logic [1:0]  in_sel;
    logic [2:0]  in_rd;
    logic        in_we;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic        rf_we;
    logic [2:0]  rf_waddr;
    logic [15:0] rf_wdata;
    logic        err;
    logic        busy;

    modport slave (
        input  in_valid, in_alu, in_pc, in_imm, in_sel, in_rd, in_we, mem_ack, mem_rdata,
        output in_ready, mem_req, mem_addr, rf_we, rf_waddr, rf_wdata, err, busy
    );

    modport master (
        output in_valid, in_alu, in_pc, in_imm, in_sel, in_rd, in_we, mem_ack, mem_rdata,
        input  in_ready, mem_req, mem_addr, rf_we, rf_waddr, rf_wdata, err, busy
    );
endinterface

// File: rtl/wb_stage.sv
// Writeback stage: selects ALU/load/PC+2/immediate, sequences one load read with timeout,
// and drives the register-file write port for exactly one cycle per instruction.
//
// state | meaning
// IDLE  | no instruction held, ready to accept
// MEM   | load request outstanding, counting toward TIMEOUT
// WB    | register-file write cycle; may accept the next instruction
module wb_stage #(
    parameter int TIMEOUT = 15,
    parameter bit ZERO_R0 = 1'b1
) (
    input logic       clk,
    input logic       rst_n,
    wb_stage_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MEM  = 2'd1,
        ST_WB   = 2'd2
    } state_e;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [15:0] alu_q, alu_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] imm_q, imm_d;
    logic [1:0]  sel_q, sel_d;
    logic [2:0]  rd_q, rd_d;
    logic        we_q, we_d;
    logic [15:0] ldata_q, ldata_d;
    logic        tout_q, tout_d;

    logic        ready;
    logic        accept;
    logic [15:0] wb_value;

    assign ready  = rst_n && (state_q == ST_IDLE || state_q == ST_WB);
    assign accept = bus.in_valid && ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        alu_d   = alu_q;
        pc_d    = pc_q;
        imm_d   = imm_q;
        sel_d   = sel_q;
        rd_d    = rd_q;
        we_d    = we_q;
        ldata_d = ldata_q;
        tout_d  = tout_q;

        if (state_q == ST_MEM) begin
            cnt_d = cnt_q + 8'd1;
            // Ack has priority over a timeout landing on the same cycle.
            if (bus.mem_ack) begin
                ldata_d = bus.mem_rdata;
                tout_d  = 1'b0;
                cnt_d   = 8'd0;
                state_d = ST_WB;
            end else if (cnt_q == CNT_LAST) begin
                ldata_d = 16'hFFFF;
                tout_d  = 1'b1;
                cnt_d   = 8'd0;
                state_d = ST_WB;
            end
        end else if (accept) begin
            alu_d   = bus.in_alu;
            pc_d    = bus.in_pc;
            imm_d   = bus.in_imm;
            sel_d   = bus.in_sel;
            rd_d    = bus.in_rd;
            we_d    = bus.in_we;
            tout_d  = 1'b0;
            cnt_d   = 8'd0;
            state_d = (bus.in_sel == 2'b01) ? ST_MEM : ST_WB;
        end else begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 8'd0;
            alu_q   <= 16'd0;
            pc_q    <= 16'd0;
            imm_q   <= 16'd0;
            sel_q   <= 2'd0;
            rd_q    <= 3'd0;
            we_q    <= 1'b0;
            ldata_q <= 16'd0;
            tout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            alu_q   <= alu_d;
            pc_q    <= pc_d;
            imm_q   <= imm_d;
            sel_q   <= sel_d;
            rd_q    <= rd_d;
            we_q    <= we_d;
            ldata_q <= ldata_d;
            tout_q  <= tout_d;
        end
    end

    always_comb begin
        wb_value = alu_q;
        case (sel_q)
            2'b00:   wb_value = alu_q;
            2'b01:   wb_value = ldata_q;
            2'b10:   wb_value = pc_q + 16'd2;
            default: wb_value = imm_q;
        endcase
    end

    always_comb begin
        bus.in_ready = ready;
        bus.mem_req  = 1'b0;
        bus.mem_addr = 16'd0;
        bus.rf_we    = 1'b0;
        bus.rf_waddr = 3'd0;
        bus.rf_wdata = 16'd0;
        bus.err      = 1'b0;
        bus.busy     = 1'b0;
        if (state_q == ST_MEM) begin
            bus.mem_req  = 1'b1;
            bus.mem_addr = alu_q;
            bus.busy     = 1'b1;
        end else if (state_q == ST_WB) begin
            bus.rf_we    = we_q && !(ZERO_R0 && rd_q == 3'd0);
            bus.rf_waddr = rd_q;
            bus.rf_wdata = wb_value;
            bus.err      = tout_q;
            bus.busy     = 1'b1;
        end
    end

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: two instances (ZERO_R0=1 and ZERO_R0=0) share one stimulus stream;
// expectations come from a transaction-level model of the writeback rules.
module tb_wb_stage;

    localparam int TIMEOUT = 15;
    localparam int NO_ACK  = 99;

    logic clk;
    logic rst_n;

    logic        in_valid;
    logic [15:0] in_alu, in_pc, in_imm;
    logic [1:0]  in_sel;
    logic [2:0]  in_rd;
    logic        in_we;
    logic        mem_ack;
    logic [15:0] mem_rdata;

    int checks;
    int failures;

    wb_stage_if if0 ();
    wb_stage_if if1 ();

    assign if0.in_valid  = in_valid;   assign if1.in_valid  = in_valid;
    assign if0.in_alu    = in_alu;     assign if1.in_alu    = in_alu;
    assign if0.in_pc     = in_pc;      assign if1.in_pc     = in_pc;
    assign if0.in_imm    = in_imm;     assign if1.in_imm    = in_imm;
    assign if0.in_sel    = in_sel;     assign if1.in_sel    = in_sel;
    assign if0.in_rd     = in_rd;      assign if1.in_rd     = in_rd;
    assign if0.in_we     = in_we;      assign if1.in_we     = in_we;
    assign if0.mem_ack   = mem_ack;    assign if1.mem_ack   = mem_ack;
    assign if0.mem_rdata = mem_rdata;  assign if1.mem_rdata = mem_rdata;

    wb_stage #(.TIMEOUT(TIMEOUT), .ZERO_R0(1'b1)) u_z1 (.clk(clk), .rst_n(rst_n), .bus(if0));
    wb_stage #(.TIMEOUT(TIMEOUT), .ZERO_R0(1'b0)) u_z0 (.clk(clk), .rst_n(rst_n), .bus(if1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Compare every output of both instances; only rf_we may differ between them.
    task automatic expect_all(input string tag, input logic e_ready, input logic e_req,
                              input logic [15:0] e_addr, input logic e_we_z1, input logic e_we_z0,
                              input logic [2:0] e_waddr, input logic [15:0] e_wdata,
                              input logic e_err, input logic e_busy);
        chk({tag, ".in_ready"}, {15'd0, if0.in_ready}, {15'd0, e_ready});
        chk({tag, ".mem_req"},  {15'd0, if0.mem_req},  {15'd0, e_req});
        chk({tag, ".mem_addr"}, if0.mem_addr, e_addr);
        chk({tag, ".rf_we_z1"}, {15'd0, if0.rf_we}, {15'd0, e_we_z1});
        chk({tag, ".rf_we_z0"}, {15'd0, if1.rf_we}, {15'd0, e_we_z0});
        chk({tag, ".rf_waddr"}, {13'd0, if0.rf_waddr}, {13'd0, e_waddr});
        chk({tag, ".rf_wdata"}, if0.rf_wdata, e_wdata);
        chk({tag, ".err"},      {15'd0, if0.err},  {15'd0, e_err});
        chk({tag, ".busy"},     {15'd0, if0.busy}, {15'd0, e_busy});
        chk({tag, ".z0_wdata"}, if1.rf_wdata, e_wdata);
        chk({tag, ".z0_err"},   {15'd0, if1.err},  {15'd0, e_err});
        chk({tag, ".z0_req"},   {15'd0, if1.mem_req}, {15'd0, e_req});
    endtask

    function automatic logic [15:0] ref_value(input logic [1:0] sel, input logic [15:0] alu,
                                              input logic [15:0] pc, input logic [15:0] imm,
                                              input logic [15:0] ld);
        logic [15:0] pc2;
        pc2 = pc + 16'd2;
        case (sel)
            2'b00:   return alu;
            2'b01:   return ld;
            2'b10:   return pc2;
            default: return imm;
        endcase
    endfunction

    // Entered at a negedge with the stage ready; returns at the negedge of the WB cycle.
    // ack_at: MEM cycle (1-based) whose edge samples mem_ack; > TIMEOUT means never.
    task automatic run_instr(input string tag, input logic [1:0] sel, input logic [15:0] alu,
                             input logic [15:0] pc, input logic [15:0] imm, input logic [2:0] rd,
                             input logic we, input int ack_at, input logic [15:0] rdata);
        logic [15:0] ld;
        logic        tmo;
        ld  = 16'd0;
        tmo = 1'b0;
        in_valid = 1'b1; in_sel = sel; in_alu = alu; in_pc = pc; in_imm = imm;
        in_rd = rd; in_we = we;
        mem_ack = 1'($urandom); mem_rdata = 16'($urandom);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_alu = 16'($urandom); in_pc = 16'($urandom); in_imm = 16'($urandom);
        if (sel == 2'b01) begin
            for (int k = 1; k <= TIMEOUT; k++) begin
                expect_all({tag, ".mem"}, 1'b0, 1'b1, alu, 1'b0, 1'b0, 3'd0, 16'd0, 1'b0, 1'b1);
                mem_ack   = (k == ack_at);
                mem_rdata = (k == ack_at) ? rdata : 16'($urandom);
                @(posedge clk);
                @(negedge clk);
                mem_ack = 1'b0;
                if (k == ack_at) break;
            end
            tmo = (ack_at > TIMEOUT);
            ld  = tmo ? 16'hFFFF : rdata;
        end
        expect_all({tag, ".wb"}, 1'b1, 1'b0, 16'd0, we && (rd != 3'd0), we, rd,
                   ref_value(sel, alu, pc, imm, ld), tmo, 1'b1);
    endtask

    task automatic idle_cycle(input string tag);
        in_valid = 1'b0;
        mem_ack  = 1'($urandom);
        @(posedge clk);
        @(negedge clk);
        expect_all(tag, 1'b1, 1'b0, 16'd0, 1'b0, 1'b0, 3'd0, 16'd0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [1:0] r_sel;
        int         r_ack;
        checks = 0;
        failures = 0;
        rst_n = 1'b0;
        in_valid = 1'b1; in_sel = 2'b00; in_alu = 16'h1111; in_pc = 16'h2222;
        in_imm = 16'h3333; in_rd = 3'd1; in_we = 1'b1; mem_ack = 1'b0; mem_rdata = 16'd0;

        // Reset held with in_valid asserted
        repeat (2) @(posedge clk);
        @(negedge clk);
        expect_all("reset", 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 3'd0, 16'd0, 1'b0, 1'b0);
        rst_n = 1'b1;
        in_valid = 1'b0;
        #1;
        expect_all("release", 1'b1, 1'b0, 16'd0, 1'b0, 1'b0, 3'd0, 16'd0, 1'b0, 1'b0);
        @(negedge clk);

        // Each select, back-to-back
        run_instr("alu",  2'b00, 16'h1234, 16'h0100, 16'h0000, 3'd3, 1'b1, 0, 16'd0);
        run_instr("imm",  2'b11, 16'h0000, 16'hFFFE, 16'hABCD, 3'd4, 1'b1, 0, 16'd0);
        run_instr("pc2",  2'b10, 16'h0000, 16'hFFFE, 16'hABCD, 3'd6, 1'b1, 0, 16'd0);
        run_instr("ld1",  2'b01, 16'h0080, 16'hFFFE, 16'hABCD, 3'd2, 1'b1, 1, 16'h00C3);
        idle_cycle("after_b2b");

        // Load with 3 wait cycles, timeout, and ack on the last allowed cycle
        run_instr("load", 2'b01, 16'h0040, 16'h0200, 16'h0000, 3'd5, 1'b1, 3, 16'h5A5A);
        idle_cycle("after_load");
        run_instr("tmo",  2'b01, 16'h0044, 16'h0200, 16'h0000, 3'd7, 1'b1, NO_ACK, 16'h0000);
        idle_cycle("after_tmo");
        run_instr("ack15", 2'b01, 16'h0048, 16'h0200, 16'h0000, 3'd7, 1'b1, TIMEOUT, 16'h7E57);
        idle_cycle("after_ack15");

        // r0 handling and non-writing load
        run_instr("rd0",  2'b00, 16'hBEEF, 16'h0000, 16'h0000, 3'd0, 1'b1, 0, 16'd0);
        run_instr("we0ld", 2'b01, 16'h0050, 16'h0000, 16'h0000, 3'd1, 1'b0, 2, 16'h1357);
        idle_cycle("after_we0");

        // Reset during MEM, then a stray ack
        in_valid = 1'b1; in_sel = 2'b01; in_alu = 16'h0060; in_rd = 3'd2; in_we = 1'b1;
        mem_ack = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        expect_all("rstmem.c1", 1'b0, 1'b1, 16'h0060, 1'b0, 1'b0, 3'd0, 16'd0, 1'b0, 1'b1);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        expect_all("rstmem.rst", 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 3'd0, 16'd0, 1'b0, 1'b0);
        rst_n = 1'b1;
        mem_ack = 1'b1;
        mem_rdata = 16'hDEAD;
        @(posedge clk);
        @(negedge clk);
        mem_ack = 1'b0;
        expect_all("rstmem.late", 1'b1, 1'b0, 16'd0, 1'b0, 1'b0, 3'd0, 16'd0, 1'b0, 1'b0);
        idle_cycle("rstmem.idle");

        // Randomised instruction stream with occasional gaps and timeouts
        for (int i = 0; i < 40; i++) begin
            r_sel = 2'($urandom);
            r_ack = ($urandom_range(0, 7) == 0) ? NO_ACK : int'($urandom_range(1, 5));
            run_instr("rand", r_sel, 16'($urandom), 16'($urandom), 16'($urandom),
                      3'($urandom), 1'($urandom), r_ack, 16'($urandom));
            if ($urandom_range(0, 3) == 0) idle_cycle("rand_gap");
        end
        idle_cycle("final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
